// File: rtl/instr_mem_loader_if.sv
// Instruction-memory loader bus: operator controls, instruction RAM port and status outputs.
// The loader takes the master view; the operator/RAM environment takes the slave view.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
);
  logic              LoadMode;
  logic              Enter;
  logic              Finish;
  logic [DATA_W-1:0] DataIn;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWrData;
  logic              MemWe;
  logic [DATA_W-1:0] MemRdData;
  logic              CpuHold;
  logic [ADDR_W:0]   WordCount;
  logic              Err;
  logic [3:0]        State;

  modport master (
    input  LoadMode, Enter, Finish, DataIn, MemRdData,
    output MemAddr, MemWrData, MemWe, CpuHold, WordCount, Err, State
  );

  modport slave (
    output LoadMode, Enter, Finish, DataIn, MemRdData,
    input  MemAddr, MemWrData, MemWe, CpuHold, WordCount, Err, State
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Writes operator-entered words into instruction RAM at auto-incrementing addresses,
// reads each one back and verifies it, holding the CPU for the whole session.
module instr_mem_loader #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
) (
  input  logic                Clk,
  input  logic                ResetN,
  instr_mem_loader_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'h0,
    S_ARMED = 4'h1,
    S_WRITE = 4'h2,
    S_READ  = 4'h3,
    S_CHECK = 4'h4,
    S_DONE  = 4'h5,
    S_ERROR = 4'hF
  } state_e;

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.LoadMode) begin
          state_d = S_ARMED;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_ARMED: begin
        // Enter outranks Finish; a simultaneous Finish is simply lost.
        if (!bus.LoadMode) begin
          state_d = S_IDLE;
        end else if (bus.Enter) begin
          wdata_d = bus.DataIn;
          state_d = S_WRITE;
        end else if (bus.Finish) begin
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (bus.MemRdData != wdata_q) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
          // Last slot filled: park on the final address rather than wrapping.
          if (count_d == FULL) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_ARMED;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (!bus.LoadMode) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    we_d   = (state_d == S_WRITE);
    hold_d = (state_d != S_IDLE);
  end

  assign bus.State     = state_q;
  assign bus.MemAddr   = addr_q;
  assign bus.MemWrData = wdata_q;
  assign bus.MemWe     = we_q;
  assign bus.CpuHold   = hold_q;
  assign bus.WordCount = count_q;
  assign bus.Err       = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: session-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized operator activity.
module tb_instr_mem_loader;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  always #5 Clk = ~Clk;

  instr_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // Instruction RAM with optional bit-0 corruption on read of one address.
  logic [DATA_W-1:0] ram [DEPTH];
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  int                we_cnt = 0;

  always @(posedge Clk) begin
    if (bus.MemWe) ram[bus.MemAddr] <= bus.MemWrData;
    bus.MemRdData <= ram[bus.MemAddr] ^
                     ((corrupt_en && bus.MemAddr == corrupt_addr) ? 16'h0001 : 16'h0000);
    if (bus.MemWe) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: session mode plus how far into the current word we are.
  // m_sess: 0 idle, 1 armed, 2 done, 3 error. m_phase: cycles elapsed into a word (0 = none).
  int              m_sess = 0;
  int              m_phase = 0;
  int              m_addr = 0;
  int              m_count = 0;
  logic [15:0]     m_wdata = '0;
  bit              m_err = 1'b0;

  task automatic model_step();
    if (!ResetN) begin
      m_sess = 0; m_phase = 0; m_addr = 0; m_count = 0; m_wdata = '0; m_err = 1'b0;
    end else if (m_phase != 0) begin
      if (m_phase == 3) begin
        m_phase = 0;
        if (corrupt_en && m_addr == int'(corrupt_addr)) begin
          m_sess = 3;
          m_err  = 1'b1;
        end else begin
          m_count++;
          if (m_count == DEPTH) m_sess = 2;
          else begin
            m_addr++;
            m_sess = 1;
          end
        end
      end else begin
        m_phase++;
      end
    end else begin
      case (m_sess)
        0: if (bus.LoadMode) begin
             m_sess = 1; m_addr = 0; m_count = 0; m_err = 1'b0;
           end
        1: if (!bus.LoadMode) m_sess = 0;
           else if (bus.Enter) begin
             m_wdata = bus.DataIn;
             m_phase = 1;
           end else if (bus.Finish) m_sess = 2;
        default: if (!bus.LoadMode) m_sess = 0;
      endcase
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  initial forever begin
    logic [3:0] es;
    @(negedge Clk);
    if (cmp_en) begin
      if (m_phase != 0) es = 4'(m_phase + 1);
      else es = (m_sess == 0) ? 4'h0 : (m_sess == 1) ? 4'h1 : (m_sess == 2) ? 4'h5 : 4'hF;
      chk("State",     32'(bus.State),     32'(es));
      chk("MemWe",     32'(bus.MemWe),     32'(m_phase == 1));
      chk("MemAddr",   32'(bus.MemAddr),   m_addr);
      chk("MemWrData", 32'(bus.MemWrData), 32'(m_wdata));
      chk("CpuHold",   32'(bus.CpuHold),   32'(m_phase != 0 || m_sess != 0));
      chk("WordCount", 32'(bus.WordCount), m_count);
      chk("Err",       32'(bus.Err),       32'(m_err));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_enter();
    bus.Enter = 1'b1;
    tick();
    bus.Enter = 1'b0;
  endtask

  task automatic word(input logic [15:0] d);
    bus.DataIn = d;
    pulse_enter();
    repeat (3) tick();
  endtask

  initial begin
    int w0;
    int bad;
    bus.LoadMode = 1'b0;
    bus.Enter    = 1'b0;
    bus.Finish   = 1'b0;
    bus.DataIn   = '0;
    for (int i = 0; i < int'(DEPTH); i++) ram[i] = '0;

    ResetN = 1'b0;
    tick(); tick();
    cmp_en = 1'b1;
    chk("rst State", 32'(bus.State), 32'h0);
    chk("rst MemAddr", 32'(bus.MemAddr), 32'h0);
    chk("rst MemWe", 32'(bus.MemWe), 32'h0);
    chk("rst CpuHold", 32'(bus.CpuHold), 32'h0);
    chk("rst WordCount", 32'(bus.WordCount), 32'h0);
    chk("rst Err", 32'(bus.Err), 32'h0);
    ResetN = 1'b1;

    // Single word: one-cycle Enter-to-write latency, four cycles back to ARMED.
    bus.LoadMode = 1'b1;
    tick();
    bus.DataIn = 16'h1234;
    pulse_enter();
    chk("t1 MemWe", 32'(bus.MemWe), 32'h1);
    chk("t1 MemAddr", 32'(bus.MemAddr), 32'h0);
    chk("t1 MemWrData", 32'(bus.MemWrData), 32'h1234);
    repeat (3) tick();
    chk("t1 State", 32'(bus.State), 32'h1);
    chk("t1 WordCount", 32'(bus.WordCount), 32'h1);
    chk("t1 MemAddr+1", 32'(bus.MemAddr), 32'h1);
    chk("t1 CpuHold", 32'(bus.CpuHold), 32'h1);

    // Three words then Finish.
    bus.LoadMode = 1'b0; tick();
    bus.LoadMode = 1'b1; tick();
    word(16'hA001); word(16'hB002); word(16'hC003);
    bus.Finish = 1'b1; tick(); bus.Finish = 1'b0;
    chk("t2 State", 32'(bus.State), 32'h5);
    chk("t2 WordCount", 32'(bus.WordCount), 32'h3);
    bus.LoadMode = 1'b0; tick();
    chk("t2 idle State", 32'(bus.State), 32'h0);
    chk("t2 CpuHold", 32'(bus.CpuHold), 32'h0);
    chk("t2 ram0", 32'(ram[0]), 32'hA001);
    chk("t2 ram1", 32'(ram[1]), 32'hB002);
    chk("t2 ram2", 32'(ram[2]), 32'hC003);

    // Read-back corruption at address 1.
    corrupt_en = 1'b1; corrupt_addr = 7'd1;
    bus.LoadMode = 1'b1; tick();
    word(16'h5555); word(16'h6666);
    chk("t3 State", 32'(bus.State), 32'hF);
    chk("t3 Err", 32'(bus.Err), 32'h1);
    chk("t3 MemAddr", 32'(bus.MemAddr), 32'h1);
    bus.LoadMode = 1'b0; tick();
    chk("t3 idle State", 32'(bus.State), 32'h0);
    chk("t3 idle Err", 32'(bus.Err), 32'h1);
    bus.LoadMode = 1'b1; tick();
    chk("t3 new Err", 32'(bus.Err), 32'h0);
    corrupt_en = 1'b0;

    // Fill the whole memory.
    for (int i = 0; i < int'(DEPTH); i++) word(16'(i));
    chk("t4 State", 32'(bus.State), 32'h5);
    chk("t4 WordCount", 32'(bus.WordCount), 32'd128);
    chk("t4 MemAddr", 32'(bus.MemAddr), 32'h7F);
    bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== 16'(i)) bad++;
    chk("t4 ram fill", 32'(bad), 32'h0);
    w0 = we_cnt;
    bus.DataIn = 16'hFFFF;
    pulse_enter();
    repeat (3) tick();
    chk("t4 extra Enter", 32'(we_cnt - w0), 32'h0);

    // Enter+Finish together, and Enter during READ.
    bus.LoadMode = 1'b0; tick();
    bus.LoadMode = 1'b1; tick();
    w0 = we_cnt;
    bus.DataIn = 16'hABCD; bus.Enter = 1'b1; bus.Finish = 1'b1;
    tick();
    bus.Enter = 1'b0; bus.Finish = 1'b0;
    tick();
    bus.Enter = 1'b1; tick(); bus.Enter = 1'b0;
    tick();
    chk("t5 State", 32'(bus.State), 32'h1);
    chk("t5 writes", 32'(we_cnt - w0), 32'h1);
    chk("t5 WordCount", 32'(bus.WordCount), 32'h1);

    // Reset in the middle of a write, then abort from ARMED.
    bus.DataIn = 16'h0F0F;
    pulse_enter();
    ResetN = 1'b0; tick();
    chk("t6 MemWe", 32'(bus.MemWe), 32'h0);
    chk("t6 State", 32'(bus.State), 32'h0);
    chk("t6 MemWrData", 32'(bus.MemWrData), 32'h0);
    chk("t6 WordCount", 32'(bus.WordCount), 32'h0);
    ResetN = 1'b1; tick();
    chk("t6 armed", 32'(bus.State), 32'h1);
    bus.LoadMode = 1'b0; tick();
    chk("t6 abort State", 32'(bus.State), 32'h0);
    chk("t6 abort CpuHold", 32'(bus.CpuHold), 32'h0);

    // Randomized operator activity against the model.
    corrupt_en = 1'b1;
    corrupt_addr = 7'($urandom_range(2, 12));
    for (int c = 0; c < 4000; c++) begin
      if (bus.LoadMode) bus.LoadMode = ($urandom % 60) != 0;
      else bus.LoadMode = ($urandom % 4) == 0;
      bus.Enter  = ($urandom % 4) == 0;
      bus.Finish = ($urandom % 25) == 0;
      bus.DataIn = 16'($urandom);
      ResetN     = ($urandom % 500) != 0;
      tick();
    end
    ResetN = 1'b1; bus.Enter = 1'b0; bus.Finish = 1'b0; bus.LoadMode = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
